// File: rtl/sub_serial_pkg.sv
// Shared types and helpers for the bit-serial subtractor (sub_serial).
package sub_serial_pkg;

  // Controller states, encoded 0/1/2.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } stateT;

  // Width of the bit counter: clog2 of the operand width, never below one bit.
  function automatic int counterWidth(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
module full_subtractor_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit and borrow out of a single column.
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/sub_serial.sv
// Bit-serial subtractor: result = leftInput - rightInput, one bit per clock,
// LSB first, with a start/busy/done handshake.
// Optional build macro SUB_SERIAL_OVERFLOW_EN adds a registered signed
// overflow output loaded together with result.
module sub_serial
  import sub_serial_pkg::*;
#(
  parameter int numberOfBits = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [numberOfBits-1:0] leftInput,
  input  logic [numberOfBits-1:0] rightInput,
  output logic [numberOfBits-1:0] result,
  output logic                    borrow,
`ifdef SUB_SERIAL_OVERFLOW_EN
  output logic                    overflow,
`endif
  output logic                    busy,
  output logic                    done
);

  localparam int CW = counterWidth(numberOfBits);
  localparam logic [CW-1:0] lastBit = CW'(numberOfBits - 1);

  stateT                   stateReg;
  logic [CW-1:0]           bitCountReg;
  logic                    borrowReg;
  logic [numberOfBits-1:0] leftShiftReg;
  logic [numberOfBits-1:0] rightShiftReg;
  logic [numberOfBits-1:0] diffShiftReg;
  logic                    diffBit;
  logic                    borrowOut;

`ifdef SUB_SERIAL_OVERFLOW_EN
  // Operand sign bits kept from acceptance; the shift registers lose them.
  logic leftMsbReg;
  logic rightMsbReg;
`endif

  // The single column subtractor is reused every RUN cycle on the operand LSBs.
  full_subtractor_bit columnSub (
    .a    (leftShiftReg[0]),
    .b    (rightShiftReg[0]),
    .bin  (borrowReg),
    .d    (diffBit),
    .bout (borrowOut)
  );

  // Controller, serial datapath and registered handshake/result outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stateReg      <= IDLE;
      bitCountReg   <= '0;
      borrowReg     <= 1'b0;
      leftShiftReg  <= '0;
      rightShiftReg <= '0;
      diffShiftReg  <= '0;
      result        <= '0;
      borrow        <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
`ifdef SUB_SERIAL_OVERFLOW_EN
      leftMsbReg    <= 1'b0;
      rightMsbReg   <= 1'b0;
      overflow      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (stateReg)
        IDLE: begin
          if (start) begin
            leftShiftReg  <= leftInput;
            rightShiftReg <= rightInput;
            borrowReg     <= 1'b0;
            bitCountReg   <= '0;
            busy          <= 1'b1;
            stateReg      <= RUN;
`ifdef SUB_SERIAL_OVERFLOW_EN
            leftMsbReg    <= leftInput[numberOfBits-1];
            rightMsbReg   <= rightInput[numberOfBits-1];
`endif
          end
        end
        RUN: begin
          // Difference bits enter at the MSB so bit 0 ends up at the LSB.
          diffShiftReg  <= {diffBit, diffShiftReg[numberOfBits-1:1]};
          leftShiftReg  <= {1'b0, leftShiftReg[numberOfBits-1:1]};
          rightShiftReg <= {1'b0, rightShiftReg[numberOfBits-1:1]};
          borrowReg     <= borrowOut;
          bitCountReg   <= bitCountReg + 1'b1;
          if (bitCountReg == lastBit) begin
            busy     <= 1'b0;
            stateReg <= DONE;
          end
        end
        DONE: begin
          result   <= diffShiftReg;
          borrow   <= borrowReg;
          done     <= 1'b1;
          stateReg <= IDLE;
`ifdef SUB_SERIAL_OVERFLOW_EN
          overflow <= (leftMsbReg != rightMsbReg) &&
                      (diffShiftReg[numberOfBits-1] != leftMsbReg);
`endif
        end
        default: begin
          stateReg <= IDLE;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/sub_serial.md
Name: sub_serial

Overview:
- Sequential bit-serial subtractor; the inverse operation of the team's parallel combinational adder.
- Computes leftInput - rightInput one bit per clock, LSB first, with a start/busy/done handshake.
- Used in the arithmetic datapath where area matters more than latency; it pairs with the adder for add/sub flows.

Parameters:
numberOfBits, 8, operand and result width (>= 2)

Ports:
clock  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
leftInput  input  numberOfBits  minuend, captured on the accepted start
rightInput  input  numberOfBits  subtrahend, captured on the accepted start
result  output  numberOfBits  difference modulo 2^numberOfBits
borrow  output  1  unsigned borrow out (1 when leftInput < rightInput)
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when result/borrow are updated

Behaviour:
- Interface: one clock (clock); reset is asynchronous and active-high (reset).
- Reset values: result=0, borrow=0, busy=0, done=0. Internally: state=IDLE, bit counter=0, borrow flop=0, operand shift registers=0.
- FSM states:
  - IDLE -> RUN on a clock edge with start=1. Operands are latched into shift registers, borrow flop cleared, counter=0, busy=1 from the next cycle.
  - RUN: each edge computes bit i:
    - d = a_i ^ b_i ^ bin
    - bout = (~a_i & b_i) | (~(a_i ^ b_i) & bin)
    - d shifts into the result shift register MSB side; operands shift right; counter increments.
    - After the edge processing bit numberOfBits-1: RUN -> DONE.
  - DONE: result and borrow output registers load the completed value; done=1 and busy=0 for exactly this one cycle; next edge -> IDLE.
- Latency: start sampled at edge k; done high in the cycle following edge k+numberOfBits+1. numberOfBits+1 edges after acceptance; result visible with done.
- Throughput: a new start is accepted in the IDLE cycle after DONE, giving one operation per numberOfBits+2 cycles.
- start while busy or in DONE: ignored, no queuing. Operand changes after acceptance have no effect.
- result/borrow are held stable between done pulses; they change only in DONE.
- Reset mid-operation: immediate abort, all outputs to their reset values, no done pulse.
- Counter width: clog2(numberOfBits). Wrap-around of the counter is never reached because the FSM leaves RUN first.

Optional Feature:
- SUB_SERIAL_OVERFLOW_EN defined:
  - Adds output port overflow (1 bit, reset 0), loaded in DONE alongside result.
  - overflow = signed two's-complement overflow = (a_msb != b_msb) && (result_msb != a_msb), using the latched operand MSBs.
- Undefined: no overflow port and no extra flops; all other behaviour identical.

Decomposition:
- Shared package sub_serial_pkg:
  - State enum IDLE/RUN/DONE (2-bit encoding 0/1/2).
  - Function for counter width.
- One natural sub-module: full_subtractor_bit (combinational a, b, bin -> d, bout), instantiated once and reused each cycle.

Test Plan:
- numberOfBits=8, start with 200 and 55 -> done after 9 edges, result=145, borrow=0, busy high for the 8 RUN cycles.
- 5 - 10 -> result=251, borrow=1; 0 - 0 -> result=0, borrow=0; 255 - 255 -> result=0, borrow=0.
- Back-to-back: start held high continuously with 100 - 1 then 50 - 60 -> two done pulses 10 cycles apart; results 99/borrow 0 then 246/borrow 1. Starts during busy are ignored.
- Change leftInput/rightInput every cycle during RUN after accepting 77 - 33 -> result=44 unaffected.
- Assert reset at RUN bit 4 of 9 - 3 -> outputs 0, no done pulse; a following 9 - 3 completes with result=6.
- With SUB_SERIAL_OVERFLOW_EN: 8'h80 - 8'h01 -> result=8'h7F, overflow=1, borrow=0; 8'h10 - 8'h01 -> overflow=0.
